smg_display_ctrl: RTL and testbench

//  Sequencer for a 4-digit multiplexed 7-segment display (common anode, active-low digit and segment drive).

---
 rtl/smg_pkg.sv | 27 ++
 rtl/smg_seg_decode.sv | 38 +++
 rtl/smg_display_ctrl.sv | 150 +++++++++++++++
 tb/tb_smg_display_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/smg_pkg.sv
// Shared constants and types for the 4-digit 7-segment display sequencer.
// Segment codes are active-low {dp,g,f,e,d,c,b,a} with the dp bit off.
// Covers the decoder, the blank/show slot states and the all-off drive values.
package smg_pkg;

    localparam logic [7:0] SEG_0   = 8'hC0;
    localparam logic [7:0] SEG_1   = 8'hF9;
    localparam logic [7:0] SEG_2   = 8'hA4;
    localparam logic [7:0] SEG_3   = 8'hB0;
    localparam logic [7:0] SEG_4   = 8'h99;
    localparam logic [7:0] SEG_5   = 8'h92;
    localparam logic [7:0] SEG_6   = 8'h82;
    localparam logic [7:0] SEG_7   = 8'hF8;
    localparam logic [7:0] SEG_8   = 8'h80;
    localparam logic [7:0] SEG_9   = 8'h90;
    localparam logic [7:0] SEG_A   = 8'h88;
    localparam logic [7:0] SEG_B   = 8'h83;
    localparam logic [7:0] SEG_C   = 8'hC6;
    localparam logic [7:0] SEG_D   = 8'hA1;
    localparam logic [7:0] SEG_E   = 8'h86;
    localparam logic [7:0] SEG_F   = 8'h8E;
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] SCAN_OFF = 4'b1111;

    typedef enum logic {ST_BLANK, ST_SHOW} slot_st_t;

endpackage

// File: rtl/smg_seg_decode.sv
// Hex nibble plus decimal point to active-low 7-segment code.
// Latency: purely combinational.
// Backpressure: none, no handshake.
module smg_seg_decode
    import smg_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       dp,
    output logic [7:0] seg
);

    logic [7:0] code;

    always_comb begin
        code = SEG_OFF;
        case (nib)
            4'h0: code = SEG_0;
            4'h1: code = SEG_1;
            4'h2: code = SEG_2;
            4'h3: code = SEG_3;
            4'h4: code = SEG_4;
            4'h5: code = SEG_5;
            4'h6: code = SEG_6;
            4'h7: code = SEG_7;
            4'h8: code = SEG_8;
            4'h9: code = SEG_9;
            4'hA: code = SEG_A;
            4'hB: code = SEG_B;
            4'hC: code = SEG_C;
            4'hD: code = SEG_D;
            4'hE: code = SEG_E;
            4'hF: code = SEG_F;
            default: code = SEG_OFF;
        endcase
        seg = dp ? (code & 8'h7F) : code;
    end

endmodule

// File: rtl/smg_display_ctrl.sv
// 4-digit multiplexed 7-segment scan sequencer; SMG_LZS_EN adds leading-zero suppression.
// Latency: pin outputs registered, one cycle behind the slot counter.
// Backpressure: DataReady low while an update is pending; it is applied at the next frame end.
module smg_display_ctrl
    import smg_pkg::*;
#(
    parameter int T1MS      = 500_000,
    parameter int BLANK_CYC = 1_000
)(
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        Enable,
    input  logic        DataValid,
    output logic        DataReady,
    input  logic [15:0] DataIn,
    input  logic [3:0]  DpIn,
    input  logic [3:0]  BlankIn,
    output logic [3:0]  ScanSig,
    output logic [7:0]  SegSig,
    output logic        FrameDone
);

    localparam int              CW       = (T1MS > 1) ? $clog2(T1MS) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(T1MS - 1);
    localparam logic [CW-1:0]   CNT_SHOW = CW'(BLANK_CYC);
    localparam slot_st_t        ST_START = (BLANK_CYC == 0) ? ST_SHOW : ST_BLANK;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    slot_q, slot_d;
    slot_st_t      st_q, st_d;
    logic          frame_end;

    logic [15:0]   act_dat, pend_dat;
    logic [3:0]    act_dp, pend_dp, act_blank, pend_blank;
    logic          pend_full;

    logic [3:0]    lzs;
    logic [3:0]    dig;
    logic          dig_dp;
    logic [7:0]    dec_seg;
    logic [3:0]    scan_d;
    logic [7:0]    seg_d;

    // Slot sequencer: counter wrap moves to the next digit, blank window opens each slot.
    always_comb begin
        cnt_d     = cnt_q;
        slot_d    = slot_q;
        st_d      = st_q;
        frame_end = 1'b0;
        if (!Enable) begin
            cnt_d  = '0;
            slot_d = 2'd3;
            st_d   = ST_START;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            slot_d    = slot_q - 2'd1;
            st_d      = ST_START;
            frame_end = (slot_q == 2'd0);
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CNT_SHOW) begin
                st_d = ST_SHOW;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt_q  <= '0;
            slot_q <= 2'd3;
            st_q   <= ST_START;
        end else begin
            cnt_q  <= cnt_d;
            slot_q <= slot_d;
            st_q   <= st_d;
        end
    end

`ifdef SMG_LZS_EN
    // Digit 0 always shows so a zero value still reads "0".
    assign lzs[3] = (act_dat[15:12] == 4'h0);
    assign lzs[2] = lzs[3] && (act_dat[11:8] == 4'h0);
    assign lzs[1] = lzs[2] && (act_dat[7:4] == 4'h0);
    assign lzs[0] = 1'b0;
`else
    assign lzs = 4'b0000;
`endif

    assign dig    = act_dat[{slot_q, 2'b00} +: 4];
    assign dig_dp = act_dp[slot_q];

    smg_seg_decode u_dec (
        .nib (dig),
        .dp  (dig_dp),
        .seg (dec_seg)
    );

    always_comb begin
        scan_d = SCAN_OFF;
        seg_d  = SEG_OFF;
        if (Enable && st_q == ST_SHOW) begin
            scan_d = ~(4'b0001 << slot_q);
            if (act_blank[slot_q]) begin
                seg_d = SEG_OFF;
            end else if (lzs[slot_q]) begin
                seg_d = {~dig_dp, 7'h7F};
            end else begin
                seg_d = dec_seg;
            end
        end
    end

    // Pending -> active only at frame end, or at once while the scan is stopped.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            act_dat    <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
            pend_dat   <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_full  <= 1'b0;
        end else if (pend_full && (frame_end || !Enable)) begin
            act_dat   <= pend_dat;
            act_dp    <= pend_dp;
            act_blank <= pend_blank;
            pend_full <= 1'b0;
        end else if (DataValid && !pend_full) begin
            pend_dat   <= DataIn;
            pend_dp    <= DpIn;
            pend_blank <= BlankIn;
            pend_full  <= 1'b1;
        end
    end

    assign DataReady = ~pend_full;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ScanSig   <= SCAN_OFF;
            SegSig    <= SEG_OFF;
            FrameDone <= 1'b0;
        end else begin
            ScanSig   <= scan_d;
            SegSig    <= seg_d;
            FrameDone <= frame_end;
        end
    end

endmodule

// File: tb/tb_smg_display_ctrl.sv
// Directed bench for smg_display_ctrl with T1MS=20, BLANK_CYC=2.
// k is the index of the last rising edge since Enable rose; outputs after edge k reflect cnt=k%20.
module tb_smg_display_ctrl;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        Enable;
    logic        DataValid;
    logic        DataReady;
    logic [15:0] DataIn;
    logic [3:0]  DpIn;
    logic [3:0]  BlankIn;
    logic [3:0]  ScanSig;
    logic [7:0]  SegSig;
    logic        FrameDone;

    int n_chk  = 0;
    int n_pass = 0;
    int k      = -1;

    always #5 CLK = ~CLK;

    smg_display_ctrl #(.T1MS(20), .BLANK_CYC(2)) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .Enable    (Enable),
        .DataValid (DataValid),
        .DataReady (DataReady),
        .DataIn    (DataIn),
        .DpIn      (DpIn),
        .BlankIn   (BlankIn),
        .ScanSig   (ScanSig),
        .SegSig    (SegSig),
        .FrameDone (FrameDone)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (k=%0d)", tag, got, exp, k);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        k++;
        @(negedge CLK);
    endtask

    task automatic run_to(input int n);
        while (k < n) tick();
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        DataIn    = d;
        DpIn      = dp;
        BlankIn   = bl;
        DataValid = 1'b1;
        tick();
        DataValid = 1'b0;
    endtask

    localparam logic [7:0] LZ_SEG =
`ifdef SMG_LZS_EN
        8'hFF;
`else
        8'hC0;
`endif

    initial begin
        int acc;
        int fd_seen;
        RSTn = 1'b0; Enable = 1'b0; DataValid = 1'b0;
        DataIn = '0; DpIn = '0; BlankIn = '0;
        repeat (3) @(negedge CLK);
        chk("rst_scan", ScanSig, 4'b1111);
        chk("rst_seg", SegSig, 8'hFF);
        chk("rst_rdy", DataReady, 1'b1);
        chk("rst_fd", FrameDone, 1'b0);
        RSTn = 1'b1;
        tick(); tick();
        chk("idle_scan", ScanSig, 4'b1111);

        // Power-up frame shows all zeros
        Enable = 1'b1; k = -1;
        run_to(1);  chk("s3_blank", ScanSig, 4'b1111);
        run_to(2);  chk("s3_scan", ScanSig, 4'b0111);  chk("s3_seg", SegSig, 8'hC0);
        run_to(21); chk("s2_blank", ScanSig, 4'b1111);
        run_to(22); chk("s2_scan", ScanSig, 4'b1011);  chk("s2_seg", SegSig, 8'hC0);

        // Mid-frame update waits for the frame boundary
        run_to(29); load(16'h12AF, 4'b0010, 4'b0000);
        chk("ld_rdy_lo", DataReady, 1'b0);
        run_to(42); chk("s1_scan_old", ScanSig, 4'b1101); chk("s1_seg_old", SegSig, 8'hC0);
        run_to(78); chk("fd_pre", FrameDone, 1'b0); chk("rdy_pre", DataReady, 1'b0);
        run_to(79); chk("fd_pulse", FrameDone, 1'b1); chk("rdy_post", DataReady, 1'b1);
        run_to(80); chk("fd_end", FrameDone, 1'b0);
        run_to(82);  chk("f2_d3", SegSig, 8'hF9);
        run_to(102); chk("f2_d2", SegSig, 8'hA4);
        run_to(122); chk("f2_d1_scan", ScanSig, 4'b1101); chk("f2_d1_dp", SegSig, 8'h08);
        run_to(142); chk("f2_d0_scan", ScanSig, 4'b1110); chk("f2_d0", SegSig, 8'h8E);

        // Back-to-back: second request held until the frame-end transfer frees the buffer
        run_to(164); load(16'h3456, 4'b0000, 4'b0000);
        DataIn = 16'h789B; DataValid = 1'b1; acc = -1;
        for (int i = 0; i < 200 && acc < 0; i++) begin
            if (DataReady) acc = k + 1;
            tick();
        end
        DataValid = 1'b0;
        chk("b2b_acc_edge", 16'(acc), 16'd240);
        run_to(242); chk("f4_d3", SegSig, 8'hB0);
        run_to(262); chk("f4_d2", SegSig, 8'h99);
        run_to(322); chk("f5_d3", SegSig, 8'hF8);
        run_to(342); chk("f5_d2", SegSig, 8'h80);

        // Enable dropped in slot 1, cnt 7
        run_to(366); Enable = 1'b0; tick();
        chk("dis_scan", ScanSig, 4'b1111); chk("dis_seg", SegSig, 8'hFF);
        fd_seen = 0;
        while (k < 400) begin
            tick();
            if (FrameDone) fd_seen++;
        end
        chk("dis_no_fd", 16'(fd_seen), 16'd0);

        // While stopped, pending applies immediately
        load(16'h0050, 4'b0000, 4'b0000);
        chk("dis_rdy_lo", DataReady, 1'b0);
        tick();
        chk("dis_rdy_back", DataReady, 1'b1);
        Enable = 1'b1; k = -1;
        run_to(2);  chk("re_scan", ScanSig, 4'b0111); chk("lz_d3", SegSig, LZ_SEG);
        run_to(22); chk("lz_d2", SegSig, LZ_SEG);
        run_to(42); chk("lz_d1", SegSig, 8'h92);
        run_to(62); chk("lz_d0", SegSig, 8'hC0);
        run_to(79); chk("re_fd", FrameDone, 1'b1);

        // Per-digit blanking
        Enable = 1'b0; tick();
        load(16'h1234, 4'b0000, 4'b0100);
        tick();
        Enable = 1'b1; k = -1;
        run_to(2);  chk("bl_d3", SegSig, 8'hF9);
        run_to(22); chk("bl_d2_scan", ScanSig, 4'b1011); chk("bl_d2_seg", SegSig, 8'hFF);
        run_to(42); chk("bl_d1", SegSig, 8'hB0);
        run_to(62); chk("bl_d0", SegSig, 8'h99);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
